// File: rtl/ps2_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ps2_receiver
// Purpose  : PS/2 device-to-host receiver with pin synchronisers, a clock
//            deglitch filter, an 11-bit frame deserialiser and a frame timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ps2_receiver #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 25000
) (
   input  logic       CLK_25MHZ,
   input  logic       RESET,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       RX_ERROR
);

   localparam int c_filt_w = $clog2(FILTER_LEN + 1);
   localparam int c_to_w   = $clog2(TIMEOUT + 1);
   localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
   localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   logic [1:0]          r_clk_sync;
   logic [1:0]          r_data_sync;
   logic [c_filt_w-1:0] r_filt_cnt;
   logic                r_filt_clk;
   logic                r_filt_clk_d;
   logic                r_strobe;
   state_t              r_state;
   logic [7:0]          r_shift;
   logic [2:0]          r_bit_cnt;
   logic                r_parity;
   logic [c_to_w-1:0]   r_to_cnt;
   logic                w_bit;

   assign w_bit = r_data_sync[1];

   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], PS2_CLK};
         r_data_sync <= {r_data_sync[0], PS2_DATA};
      end
   end

   // The filtered clock follows the pin only after FILTER_LEN steady samples;
   // the strobe is registered so the FSM sees data one cycle after the edge.
   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         r_filt_cnt   <= '0;
         r_filt_clk   <= 1'b1;
         r_filt_clk_d <= 1'b1;
         r_strobe     <= 1'b0;
      end else begin
         r_filt_clk_d <= r_filt_clk;
         r_strobe     <= r_filt_clk_d & ~r_filt_clk;
         if (r_clk_sync[1] != r_filt_clk) begin
            if (r_filt_cnt == c_filt_last) begin
               r_filt_clk <= r_clk_sync[1];
               r_filt_cnt <= '0;
            end else begin
               r_filt_cnt <= r_filt_cnt + 1'b1;
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_parity  <= 1'b0;
         r_to_cnt  <= '0;
         RX_DATA   <= '0;
         RX_VALID  <= 1'b0;
         RX_ERROR  <= 1'b0;
      end else begin
         RX_VALID <= 1'b0;
         RX_ERROR <= 1'b0;
         // A strobe wins over a timeout expiring in the same cycle.
         if (r_strobe) begin
            r_to_cnt <= '0;
            case (r_state)
               S_IDLE: begin
                  if (!w_bit) begin
                     r_shift   <= '0;
                     r_bit_cnt <= '0;
                     r_state   <= S_DATA;
                  end
               end
               S_DATA: begin
                  r_shift   <= {w_bit, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_PARITY;
                  end
               end
               S_PARITY: begin
                  r_parity <= w_bit;
                  r_state  <= S_STOP;
               end
               S_STOP: begin
                  if (((^r_shift) ^ r_parity) && w_bit) begin
                     RX_DATA  <= r_shift;
                     RX_VALID <= 1'b1;
                  end else begin
                     RX_ERROR <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end else if (r_state != S_IDLE) begin
            if (r_to_cnt == c_to_last) begin
               RX_ERROR <= 1'b1;
               r_state  <= S_IDLE;
               r_shift  <= '0;
               r_to_cnt <= '0;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end else begin
            r_to_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire
